// File: rtl/cword_pipe_pkg.sv
// Shared types for the control-word pipeline: the decoder's control word,
// forwarding select encoding, the NOP word and the forward-select helper.
package cword_pipe_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        alu_add, alu_sll, alu_sra, alu_sub,
        alu_xor, alu_srl, alu_or,  alu_and
    } alu_ops;

    typedef struct packed {
        rv32i_opcode opcode;
        alu_ops      aluop;
        logic [4:0]  rd;
        logic        load_regfile;
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  mem_wmask;
        logic        alumux1_sel;
        logic [2:0]  alumux2_sel;
        logic [3:0]  regfilemux_sel;
        logic        cmpmux_sel;
    } rv32i_control_word;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } pipe_fwd_sel_t;

    // addi x0, x0, 0 with every side effect disabled
    localparam rv32i_control_word CWORD_NOP = '{
        opcode:         op_imm,
        aluop:          alu_add,
        rd:             5'd0,
        load_regfile:   1'b0,
        mem_read:       1'b0,
        mem_write:      1'b0,
        mem_wmask:      4'h0,
        alumux1_sel:    1'b0,
        alumux2_sel:    3'd0,
        regfilemux_sel: 4'd0,
        cmpmux_sel:     1'b0
    };

    // MEM result wins over WB on the same rd; x0 and empty EX never forward.
    function automatic pipe_fwd_sel_t fwd_pick(
        input logic [4:0] src,
        input logic       ex_v,
        input logic       mem_ok,
        input logic [4:0] mem_rd,
        input logic       wb_ok,
        input logic [4:0] wb_rd
    );
        pipe_fwd_sel_t sel;
        sel = FWD_RF;
        if (ex_v && (src != 5'd0)) begin
            if (mem_ok && (mem_rd == src)) begin
                sel = FWD_MEM;
            end else if (wb_ok && (wb_rd == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/cword_pipe_if.sv
// ID-stage handoff bundle: decoder-side instruction plus the stall back to ID.
// master = decoder side, slave = cword_pipe side.
interface cword_pipe_if;
    import cword_pipe_pkg::*;

    rv32i_control_word id_cword;
    logic              id_valid;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_stall;

    modport master (
        output id_cword, id_valid, id_rs1, id_rs2,
        output id_use_rs1, id_use_rs2,
        input  id_stall
    );

    modport slave (
        input  id_cword, id_valid, id_rs1, id_rs2,
        input  id_use_rs1, id_use_rs2,
        output id_stall
    );

endinterface

// File: rtl/cword_stage_reg.sv
// One pipeline stage register {cword, valid}. bubble_i beats load_i.
// Ports: clk, rst_n, load_i, bubble_i, cword_i, valid_i -> cword_o, valid_o.
module cword_stage_reg
    import cword_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              bubble_i,
    input  rv32i_control_word cword_i,
    input  logic              valid_i,
    output rv32i_control_word cword_o,
    output logic              valid_o
);

    rv32i_control_word cword_q, cword_d;
    logic              valid_q, valid_d;

    // Invalid words are stored as NOP so no stale rd leaks downstream.
    always_comb begin
        cword_d = cword_q;
        valid_d = valid_q;
        if (bubble_i) begin
            cword_d = CWORD_NOP;
            valid_d = 1'b0;
        end else if (load_i) begin
            cword_d = valid_i ? cword_i : CWORD_NOP;
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cword_q <= CWORD_NOP;
            valid_q <= 1'b0;
        end else begin
            cword_q <= cword_d;
            valid_q <= valid_d;
        end
    end

    assign cword_o = cword_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/cword_pipe.sv
// EX/MEM/WB control-word pipe: load-use stall, EX forwarding selects,
// memory-stall freeze, branch flush and saturating stall/flush counters.
// Ports: clk, rst_n, id_if (slave), mem_stall, br_flush; stage words/valids,
// ex_rs1/2, fwd_a/b_sel, mem_read_q, mem_write_q, wb_load_regfile, counters.
module cword_pipe
    import cword_pipe_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    cword_pipe_if.slave       id_if,
    input  logic              mem_stall,
    input  logic              br_flush,
    output rv32i_control_word ex_cword,
    output logic              ex_valid,
    output rv32i_control_word mem_cword,
    output logic              mem_valid,
    output rv32i_control_word wb_cword,
    output logic              wb_valid,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output pipe_fwd_sel_t     fwd_a_sel,
    output pipe_fwd_sel_t     fwd_b_sel,
    output logic              mem_read_q,
    output logic              mem_write_q,
    output logic              wb_load_regfile,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic             lu;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             take_flush;
    logic             take_lu;
    logic             ex_bubble;
    logic             mem_fwd_ok;
    logic [4:0]       ex_rs1_q, ex_rs1_d;
    logic [4:0]       ex_rs2_q, ex_rs2_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign rs1_hit = id_if.id_use_rs1 & (id_if.id_rs1 == ex_cword.rd);
    assign rs2_hit = id_if.id_use_rs2 & (id_if.id_rs2 == ex_cword.rd);

    assign lu = ex_valid & ex_cword.mem_read & (ex_cword.rd != 5'd0)
              & id_if.id_valid & (rs1_hit | rs2_hit);

    // mem_stall > br_flush > load-use > advance
    assign take_flush = ~mem_stall & br_flush;
    assign take_lu    = ~mem_stall & ~br_flush & lu;
    assign ex_bubble  = take_flush | take_lu;

    assign id_if.id_stall = mem_stall | take_lu;

    cword_stage_reg u_ex (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (~mem_stall),
        .bubble_i (ex_bubble),
        .cword_i  (id_if.id_cword),
        .valid_i  (id_if.id_valid),
        .cword_o  (ex_cword),
        .valid_o  (ex_valid)
    );

    cword_stage_reg u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (~mem_stall),
        .bubble_i (1'b0),
        .cword_i  (ex_cword),
        .valid_i  (ex_valid),
        .cword_o  (mem_cword),
        .valid_o  (mem_valid)
    );

    // WB takes a bubble while MEM is frozen so each result retires once.
    cword_stage_reg u_wb (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (1'b1),
        .bubble_i (mem_stall),
        .cword_i  (mem_cword),
        .valid_i  (mem_valid),
        .cword_o  (wb_cword),
        .valid_o  (wb_valid)
    );

    always_comb begin
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!mem_stall) begin
            if (ex_bubble) begin
                ex_rs1_d = 5'd0;
                ex_rs2_d = 5'd0;
            end else begin
                ex_rs1_d = id_if.id_rs1;
                ex_rs2_d = id_if.id_rs2;
            end
        end
        if (take_lu && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (take_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1_q    <= 5'd0;
            ex_rs2_q    <= 5'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_rs1    = ex_rs1_q;
    assign ex_rs2    = ex_rs2_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    assign mem_read_q      = mem_valid & mem_cword.mem_read;
    assign mem_write_q     = mem_valid & mem_cword.mem_write;
    assign wb_load_regfile = wb_valid & wb_cword.load_regfile
                           & (wb_cword.rd != 5'd0);

    // A load sitting in MEM has no data yet; it falls through to WB/RF.
    assign mem_fwd_ok = mem_valid & mem_cword.load_regfile
                      & ~mem_cword.mem_read;

    assign fwd_a_sel = fwd_pick(ex_rs1_q, ex_valid, mem_fwd_ok,
                                mem_cword.rd, wb_load_regfile, wb_cword.rd);
    assign fwd_b_sel = fwd_pick(ex_rs2_q, ex_valid, mem_fwd_ok,
                                mem_cword.rd, wb_load_regfile, wb_cword.rd);

endmodule

// File: tb/tb_cword_pipe.sv
// Bench for cword_pipe: retirement scoreboard on WB plus directed
// checks of stalls, forwarding selects, flushes and counters.
module tb_cword_pipe;
    import cword_pipe_pkg::*;

    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_stall;
    logic              br_flush;
    rv32i_control_word ex_cword, mem_cword, wb_cword;
    logic              ex_valid, mem_valid, wb_valid;
    logic [4:0]        ex_rs1, ex_rs2;
    pipe_fwd_sel_t     fwd_a_sel, fwd_b_sel;
    logic              mem_read_q, mem_write_q, wb_load_regfile;
    logic [CW-1:0]     stall_cnt, flush_cnt;

    cword_pipe_if id_if ();

    cword_pipe #(.CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_if           (id_if),
        .mem_stall       (mem_stall),
        .br_flush        (br_flush),
        .ex_cword        (ex_cword),
        .ex_valid        (ex_valid),
        .mem_cword       (mem_cword),
        .mem_valid       (mem_valid),
        .wb_cword        (wb_cword),
        .wb_valid        (wb_valid),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .mem_read_q      (mem_read_q),
        .mem_write_q     (mem_write_q),
        .wb_load_regfile (wb_load_regfile),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        rv32i_opcode op;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic rv32i_control_word mk(input rv32i_opcode op,
                                             input logic [4:0] rd);
        rv32i_control_word c;
        c        = CWORD_NOP;
        c.opcode = op;
        c.rd     = rd;
        case (op)
            op_load: begin
                c.load_regfile   = 1'b1;
                c.mem_read       = 1'b1;
                c.regfilemux_sel = 4'd3;
            end
            op_store: begin
                c.mem_write = 1'b1;
                c.mem_wmask = 4'hf;
            end
            op_reg, op_imm: c.load_regfile = 1'b1;
            default: c.load_regfile = 1'b0;
        endcase
        return c;
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input rv32i_control_word cw, input logic [4:0] r1,
                         input logic [4:0] r2, input logic u1, input logic u2,
                         input logic acc);
        id_if.id_cword   = cw;
        id_if.id_valid   = 1'b1;
        id_if.id_rs1     = r1;
        id_if.id_rs2     = r2;
        id_if.id_use_rs1 = u1;
        id_if.id_use_rs2 = u2;
        if (acc) sbq.push_back('{rd: cw.rd, op: cw.opcode});
    endtask

    task automatic idle;
        id_if.id_cword   = CWORD_NOP;
        id_if.id_valid   = 1'b0;
        id_if.id_rs1     = 5'd0;
        id_if.id_rs2     = 5'd0;
        id_if.id_use_rs1 = 1'b0;
        id_if.id_use_rs2 = 1'b0;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        mem_stall = 1'b0;
        br_flush  = 1'b0;
        idle();
        sbq.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sbq.size() == 0) begin
                check("wb_extra", 32'(wb_cword.rd), 32'h0bad);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("wb_rd", 32'(wb_cword.rd), 32'(e.rd));
                check("wb_op", 32'(wb_cword.opcode), 32'(e.op));
            end
        end
    end

    initial begin
        do_reset();
        check("rst_ex_v", 32'(ex_valid), 0);
        check("rst_mem_v", 32'(mem_valid), 0);
        check("rst_wb_v", 32'(wb_valid), 0);
        check("rst_stall", 32'(id_if.id_stall), 0);
        check("rst_fwd_a", 32'(fwd_a_sel), 32'(FWD_RF));
        check("rst_fwd_b", 32'(fwd_b_sel), 32'(FWD_RF));
        check("rst_ex_cw", 32'(ex_cword), 32'(CWORD_NOP));
        check("rst_rs1", 32'(ex_rs1), 0);
        check("rst_mrd", 32'(mem_read_q), 0);
        check("rst_mwr", 32'(mem_write_q), 0);
        check("rst_wbld", 32'(wb_load_regfile), 0);

        // 1: fill, then async reset mid-cycle
        drive(mk(op_reg, 5'd9), 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
        br_flush = 1'b1;
        cyc();
        br_flush = 1'b0;
        check("t1_flush", 32'(flush_cnt), 1);
        drive(mk(op_reg, 5'd1), 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
        cyc();
        drive(mk(op_store, 5'd0), 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(mk(op_reg, 5'd3), 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        cyc();
        check("t1_full_ex", 32'(ex_valid), 1);
        check("t1_full_mem", 32'(mem_valid), 1);
        check("t1_full_wb", 32'(wb_valid), 1);
        check("t1_mwr", 32'(mem_write_q), 1);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("t1_ex_v", 32'(ex_valid), 0);
        check("t1_mem_v", 32'(mem_valid), 0);
        check("t1_wb_v", 32'(wb_valid), 0);
        check("t1_fcnt", 32'(flush_cnt), 0);
        check("t1_mem_cw", 32'(mem_cword), 32'(CWORD_NOP));
        check("t1_wb_cw", 32'(wb_cword), 32'(CWORD_NOP));
        do_reset();

        // 2: load-use stall
        drive(mk(op_load, 5'd5), 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc();
        drive(mk(op_reg, 5'd6), 5'd5, 5'd1, 1'b1, 1'b1, 1'b0);
        #1;
        check("t2_stall", 32'(id_if.id_stall), 1);
        cyc();
        check("t2_bubble", 32'(ex_valid), 0);
        check("t2_scnt", 32'(stall_cnt), 1);
        check("t2_mrd", 32'(mem_read_q), 1);
        drive(mk(op_reg, 5'd6), 5'd5, 5'd1, 1'b1, 1'b1, 1'b1);
        #1;
        check("t2_nostall", 32'(id_if.id_stall), 0);
        cyc();
        check("t2_fwd_a", 32'(fwd_a_sel), 32'(FWD_WB));
        check("t2_fwd_b", 32'(fwd_b_sel), 32'(FWD_RF));
        idle();
        repeat (3) cyc();

        // 3: ALU forwarding, x0, MEM beats WB
        drive(mk(op_reg, 5'd3), 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
        cyc();
        drive(mk(op_reg, 5'd4), 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
        #1;
        check("t3_nostall", 32'(id_if.id_stall), 0);
        cyc();
        check("t3_fwd_a", 32'(fwd_a_sel), 32'(FWD_MEM));
        check("t3_fwd_b", 32'(fwd_b_sel), 32'(FWD_MEM));
        drive(mk(op_reg, 5'd0), 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
        cyc();
        drive(mk(op_reg, 5'd9), 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        cyc();
        check("t3_x0_a", 32'(fwd_a_sel), 32'(FWD_RF));
        check("t3_x0_b", 32'(fwd_b_sel), 32'(FWD_RF));
        idle();
        cyc();
        check("t3_wb_x0_v", 32'(wb_valid), 1);
        check("t3_wb_x0_ld", 32'(wb_load_regfile), 0);
        drive(mk(op_reg, 5'd7), 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
        cyc();
        drive(mk(op_imm, 5'd7), 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc();
        drive(mk(op_reg, 5'd10), 5'd7, 5'd11, 1'b1, 1'b1, 1'b1);
        cyc();
        check("t3_prio_a", 32'(fwd_a_sel), 32'(FWD_MEM));
        check("t3_prio_b", 32'(fwd_b_sel), 32'(FWD_RF));
        check("t3_scnt", 32'(stall_cnt), 1);
        idle();
        repeat (3) cyc();

        // 4: memory stall with a load in MEM
        drive(mk(op_load, 5'd7), 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc();
        drive(mk(op_reg, 5'd12), 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
        cyc();
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(mk(op_reg, 5'd13), 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
            #1;
            check("t4_stall", 32'(id_if.id_stall), 1);
            cyc();
            check("t4_ex_rd", 32'(ex_cword.rd), 12);
            check("t4_ex_rs1", 32'(ex_rs1), 1);
            check("t4_mem_rd", 32'(mem_cword.rd), 7);
            check("t4_wb_v", 32'(wb_valid), 0);
        end
        mem_stall = 1'b0;
        drive(mk(op_reg, 5'd13), 5'd1, 5'd1, 1'b1, 1'b1, 1'b1);
        #1;
        check("t4_release", 32'(id_if.id_stall), 0);
        cyc();
        check("t4_wbld", 32'(wb_load_regfile), 1);
        check("t4_wb_rd", 32'(wb_cword.rd), 7);
        idle();
        cyc();
        check("t4_wb_next", 32'(wb_cword.rd), 12);
        check("t4_scnt", 32'(stall_cnt), 1);
        repeat (3) cyc();

        // 5: flush vs load-use, flush ignored under mem_stall
        do_reset();
        drive(mk(op_load, 5'd5), 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc();
        drive(mk(op_reg, 5'd6), 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        mem_stall = 1'b1;
        br_flush  = 1'b1;
        #1;
        check("t5_ms_stall", 32'(id_if.id_stall), 1);
        cyc();
        check("t5_ms_fcnt", 32'(flush_cnt), 0);
        check("t5_ms_ex", 32'(ex_valid), 1);
        mem_stall = 1'b0;
        #1;
        check("t5_fl_stall", 32'(id_if.id_stall), 0);
        cyc();
        br_flush = 1'b0;
        check("t5_ex_v", 32'(ex_valid), 0);
        check("t5_fcnt", 32'(flush_cnt), 1);
        check("t5_scnt", 32'(stall_cnt), 0);
        idle();
        repeat (3) cyc();

        // 6: saturating flush counter
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            br_flush = 1'b1;
            cyc();
            check("t6_fcnt", 32'(flush_cnt), (i > 3) ? 3 : i);
        end
        br_flush = 1'b0;
        cyc();
        check("t6_hold", 32'(flush_cnt), 3);

        check("sb_empty", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
